// File: rtl/data_cache_wb.sv
// Direct-mapped, write-back / write-allocate data cache with one word per line.
// Hit lookup happens as a request is accepted so the COMPARE-cycle response comes straight from registers.
//
// state     | meaning
// IDLE      | ready for a CPU request; lookup result captured on acceptance
// COMPARE   | hit: respond (and write on store); miss: launch write-back or refill
// WRITEBACK | dirty victim being written to memory
// REFILL    | requested line being read from memory
// RESPOND   | miss response pulse; store data merged into the refilled line
module data_cache_wb #(
  parameter int DATA_W  = 11,
  parameter int TAG_W   = 20,
  parameter int INDEX_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cpu_req,
  input  logic                     cpu_we,
  input  logic [INDEX_W-1:0]       cpu_index,
  input  logic [TAG_W-1:0]         cpu_tag,
  input  logic [DATA_W-1:0]        cpu_wdata,
  output logic                     cpu_ready,
  output logic                     cpu_valid,
  output logic [DATA_W-1:0]        cpu_rdata,
  output logic                     hit_miss,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [TAG_W+INDEX_W-1:0] mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic                     mem_ready,
  input  logic [DATA_W-1:0]        mem_rdata,
  output logic [15:0]              hit_count,
  output logic [15:0]              miss_count
);

  localparam int LINES = 1 << INDEX_W;

  typedef enum logic [2:0] {IDLE, COMPARE, WRITEBACK, REFILL, RESPOND} state_t;

  state_t             state;
  logic [DATA_W-1:0]  data_mem [LINES];
  logic [TAG_W-1:0]   tag_mem  [LINES];
  logic [LINES-1:0]   valid_bits;
  logic [LINES-1:0]   dirty_bits;

  logic               req_we;
  logic [INDEX_W-1:0] req_index;
  logic [TAG_W-1:0]   req_tag;
  logic [DATA_W-1:0]  req_wdata;
  logic               hit_q;

  logic               lookup_hit;
  logic               victim_dirty;
  logic               line_we;
  logic               tag_we;
  logic [DATA_W-1:0]  line_wdata;

  assign cpu_ready    = (state == IDLE);
  assign lookup_hit   = valid_bits[cpu_index] && (tag_mem[cpu_index] == cpu_tag);
  assign victim_dirty = valid_bits[req_index] && dirty_bits[req_index];

  // Array writes are gated by reset so an abandoned transaction leaves the line untouched.
  always_comb begin
    line_we    = 1'b0;
    tag_we     = 1'b0;
    line_wdata = req_wdata;
    if (rst_n) begin
      case (state)
        COMPARE: line_we = hit_q && req_we;
        REFILL: begin
          line_we    = mem_ready;
          tag_we     = mem_ready;
          line_wdata = mem_rdata;
        end
        RESPOND: line_we = req_we;
        default: line_we = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (line_we) data_mem[req_index] <= line_wdata;
    if (tag_we)  tag_mem[req_index]  <= req_tag;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      valid_bits <= '0;
      dirty_bits <= '0;
      cpu_valid  <= 1'b0;
      cpu_rdata  <= '0;
      hit_miss   <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      hit_count  <= '0;
      miss_count <= '0;
      req_we     <= 1'b0;
      req_index  <= '0;
      req_tag    <= '0;
      req_wdata  <= '0;
      hit_q      <= 1'b0;
    end else begin
      cpu_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_req) begin
            req_we    <= cpu_we;
            req_index <= cpu_index;
            req_tag   <= cpu_tag;
            req_wdata <= cpu_wdata;
            hit_q     <= lookup_hit;
            if (lookup_hit) begin
              cpu_valid <= 1'b1;
              hit_miss  <= 1'b0;
              if (!cpu_we) cpu_rdata <= data_mem[cpu_index];
            end
            state <= COMPARE;
          end
        end
        COMPARE: begin
          if (hit_q) begin
            if (hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
            if (req_we) dirty_bits[req_index] <= 1'b1;
            state <= IDLE;
          end else begin
            if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
            mem_req <= 1'b1;
            if (victim_dirty) begin
              mem_we    <= 1'b1;
              mem_addr  <= {tag_mem[req_index], req_index};
              mem_wdata <= data_mem[req_index];
              state     <= WRITEBACK;
            end else begin
              mem_we   <= 1'b0;
              mem_addr <= {req_tag, req_index};
              state    <= REFILL;
            end
          end
        end
        WRITEBACK: begin
          if (mem_ready) begin
            mem_we   <= 1'b0;
            mem_addr <= {req_tag, req_index};
            state    <= REFILL;
          end
        end
        REFILL: begin
          if (mem_ready) begin
            mem_req               <= 1'b0;
            valid_bits[req_index] <= 1'b1;
            dirty_bits[req_index] <= 1'b0;
            cpu_valid             <= 1'b1;
            hit_miss              <= 1'b1;
            if (!req_we) cpu_rdata <= mem_rdata;
            state <= RESPOND;
          end
        end
        RESPOND: begin
          if (req_we) dirty_bits[req_index] <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/data_cache_wb.md
DATA_CACHE_WB -- requirements
Module: data_cache_wb

Interface
REQ-001 SHALL have parameter DATA_W, default 11: data word width in bits.
REQ-002 SHALL have parameter TAG_W, default 20: tag width in bits.
REQ-003 SHALL have parameter INDEX_W, default 8: index width; line count = 2**INDEX_W, one word per line, direct-mapped.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-006 SHALL have port cpu_req  input  1  CPU request strobe.
REQ-007 SHALL have port cpu_we  input  1  1 = write, 0 = read.
REQ-008 SHALL have port cpu_index  input  INDEX_W  line select.
REQ-009 SHALL have port cpu_tag  input  TAG_W  request tag.
REQ-010 SHALL have port cpu_wdata  input  DATA_W  write data.
REQ-011 SHALL have port cpu_ready  output  1  cache can accept a request.
REQ-012 SHALL have port cpu_valid  output  1  one-cycle response pulse.
REQ-013 SHALL have port cpu_rdata  output  DATA_W  read data, valid with cpu_valid.
REQ-014 SHALL have port hit_miss  output  1  qualified by cpu_valid; 1 = miss, 0 = hit.
REQ-015 SHALL have port mem_req  output  1  memory request, held until mem_ready.
REQ-016 SHALL have port mem_we  output  1  1 = write-back, 0 = refill read.
REQ-017 SHALL have port mem_addr  output  TAG_W+INDEX_W  {tag, index}.
REQ-018 SHALL have port mem_wdata  output  DATA_W  write-back data.
REQ-019 SHALL have port mem_ready  input  1  memory completes current transfer this cycle.
REQ-020 SHALL have port mem_rdata  input  DATA_W  refill data, sampled when mem_req & mem_ready & ~mem_we.
REQ-021 SHALL have ports hit_count, miss_count  output  16 each  saturating event counters.

Function
REQ-022 SHALL store per line: valid bit, dirty bit, TAG_W tag, DATA_W data; write-back, write-allocate policy.
REQ-023 SHALL implement FSM states IDLE, COMPARE, WRITEBACK, REFILL, RESPOND; cpu_ready = 1 only in IDLE.
REQ-024 SHALL accept a request when cpu_req & cpu_ready, register cpu_we/index/tag/wdata, go IDLE->COMPARE; CPU inputs are ignored outside acceptance.
REQ-025 SHALL declare hit in COMPARE when line valid and stored tag == registered tag (full TAG_W compare).
REQ-026 SHALL, on read hit in COMPARE: drive cpu_valid=1, hit_miss=0, cpu_rdata=line data; next state IDLE (response one cycle after acceptance).
REQ-027 SHALL, on write hit in COMPARE: write registered wdata into line, set dirty=1, pulse cpu_valid with hit_miss=0; next IDLE.
REQ-028 SHALL, on miss in COMPARE: go WRITEBACK if victim valid & dirty, else REFILL.
REQ-029 SHALL in WRITEBACK drive mem_req=1, mem_we=1, mem_addr={victim tag, index}, mem_wdata=victim data, stable until mem_ready; on mem_ready go REFILL.
REQ-030 SHALL in REFILL drive mem_req=1, mem_we=0, mem_addr={request tag, index}; on mem_ready write mem_rdata to line, valid=1, dirty=0, tag=request tag; go RESPOND.
REQ-031 SHALL in RESPOND pulse cpu_valid=1, hit_miss=1; read: cpu_rdata=refilled data; write: overwrite line with wdata, dirty=1; next IDLE.
REQ-032 SHALL drive mem_req=0 in IDLE, COMPARE, RESPOND; mem_ready outside WRITEBACK/REFILL is ignored.
REQ-033 SHALL tolerate mem_ready asserted in the first cycle of WRITEBACK/REFILL (zero wait) and any number of wait cycles.
REQ-034 SHALL increment hit_count on each hit and miss_count on each miss in COMPARE, saturating at 16'hFFFF.
REQ-035 SHALL hold cpu_rdata at its last value when cpu_valid=0.

Reset
REQ-036 SHALL, when rst_n=0 at a clock edge, clear all valid and dirty bits, set state IDLE, and set cpu_valid, cpu_rdata, hit_miss, mem_req, mem_we, mem_addr, mem_wdata, hit_count, miss_count to 0.
REQ-037 SHALL, on reset mid-transaction, abandon the transaction with no response and no line update; tag/data arrays need no reset.
REQ-038 SHALL assert cpu_ready=1 in the first cycle after rst_n returns high.

Verification
REQ-039 SHALL cover: after reset, read idx 5 tag 0x48F -> COMPARE miss, REFILL mem_addr={0x48F,5}, mem_rdata=0x087 -> RESPOND cpu_rdata=0x087, hit_miss=1, miss_count=1.
REQ-040 SHALL cover: repeat same read -> cpu_valid one cycle after acceptance, hit_miss=0, cpu_rdata=0x087, mem_req never high, hit_count=1.
REQ-041 SHALL cover: write 0x3FF hit idx 5, then read idx 5 tag 0x001 -> WRITEBACK mem_addr={0x48F,5}, mem_wdata=0x3FF, then REFILL {0x001,5}.
REQ-042 SHALL cover: mem_ready delayed 4 cycles in REFILL -> mem_req/mem_addr stable 5 cycles, cpu_ready=0 throughout, cpu_req ignored.
REQ-043 SHALL cover: rst_n=0 during REFILL -> next cycle mem_req=0, cpu_valid=0, counters 0; subsequent read of idx 5 misses.
REQ-044 SHALL cover: 65536 hits with hit_count saturating at 0xFFFF.
